// File: rtl/mp_add_pkg.sv
// Shared definitions for the multi-precision add sequencer: FSM states and
// default operand geometry.
package mp_add_pkg;

  localparam int N_DEF     = 64;
  localparam int WORDS_DEF = 4;
  localparam int W         = N_DEF * WORDS_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : mp_add_pkg

// File: rtl/mp_add_seq.sv
// Multi-precision add sequencer: walks W-bit operands through an external
// N-bit adder one word per cycle (LSW first), chaining carries, then returns
// the W-bit sum with carry/overflow/negative/zero flags.
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int WORDS = WORDS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WORDS-1:0]   op_a,
  input  logic [N*WORDS-1:0]   op_b,
  input  logic                 op_cin,
  input  logic                 op_signed,
  output logic [N-1:0]         add_a,
  output logic [N-1:0]         add_b,
  output logic                 add_cin,
  output logic                 add_signed_en,
  input  logic [N-1:0]         add_sum,
  input  logic                 add_cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*WORDS-1:0]   result,
  output logic                 carry_out,
  output logic                 overflow,
  output logic                 negative,
  output logic                 zero
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  state_e                    state_q, state_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [WORDS-1:0][N-1:0]   a_q, a_d;
  logic [WORDS-1:0][N-1:0]   b_q, b_d;
  logic [WORDS-1:0][N-1:0]   res_q, res_d;
  logic                      signed_q, signed_d;
  logic                      carry_q, carry_d;
  logic                      zacc_q, zacc_d;
  logic                      in_ready_q, in_ready_d;
  logic                      out_valid_q, out_valid_d;
  logic                      carry_out_q, carry_out_d;
  logic                      overflow_q, overflow_d;
  logic                      negative_q, negative_d;
  logic                      zero_q, zero_d;

  logic                      running;
  logic                      a_msb, b_msb;

  assign running = (state_q == RUN);
  assign a_msb   = a_q[WORDS-1][N-1];
  assign b_msb   = b_q[WORDS-1][N-1];

  // The adder is only ever used in raw mode; the word mux parks at zero
  // outside RUN so the shared adder sees quiet inputs.
  assign add_a         = running ? a_q[idx_q] : '0;
  assign add_b         = running ? b_q[idx_q] : '0;
  assign add_cin       = running ? carry_q    : 1'b0;
  assign add_signed_en = 1'b0;

  always_comb begin
    // NOTE: every *_d starts from its current value so no path through the
    // case statement leaves a variable unassigned (which would infer a latch).
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    signed_d    = signed_q;
    carry_d     = carry_q;
    zacc_d      = zacc_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    negative_d  = negative_q;
    zero_d      = zero_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d        = op_a;
          b_d        = op_b;
          signed_d   = op_signed;
          carry_d    = op_cin;
          idx_d      = '0;
          zacc_d     = 1'b1;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end

      RUN: begin
        res_d[idx_q] = add_sum;
        carry_d      = add_cout;
        zacc_d       = zacc_q & (add_sum == '0);
        if (idx_q == LAST_IDX) begin
          // The top word is on the adder this cycle, so its sum MSB is the
          // result MSB and add_cout is the whole-operand carry.
          carry_out_d = add_cout;
          overflow_d  = signed_q ? ((a_msb == b_msb) && (add_sum[N-1] != a_msb))
                                 : add_cout;
          negative_d  = signed_q & add_sum[N-1];
          zero_d      = zacc_q & (add_sum == '0);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: the result and operand registers are reset along with the control
  // state, so a dropped transaction never leaves stale data on the outputs.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments only, so every flop samples the values
    // from before this edge regardless of statement order.
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      signed_q    <= 1'b0;
      carry_q     <= 1'b0;
      zacc_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      negative_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      signed_q    <= signed_d;
      carry_q     <= carry_d;
      zacc_q      <= zacc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      negative_q  <= negative_d;
      zero_q      <= zero_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = res_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign negative  = negative_q;
  assign zero      = zero_q;

endmodule : mp_add_seq
